// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared constants for the RV64M multiply/divide sequencer: widths, funct3 codes, FSM states.
package muldiv_seq_ctrl_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  localparam logic [2:0] MD_OP_MUL    = 3'd0;
  localparam logic [2:0] MD_OP_MULH   = 3'd1;
  localparam logic [2:0] MD_OP_MULHSU = 3'd2;
  localparam logic [2:0] MD_OP_MULHU  = 3'd3;
  localparam logic [2:0] MD_OP_DIV    = 3'd4;
  localparam logic [2:0] MD_OP_DIVU   = 3'd5;
  localparam logic [2:0] MD_OP_REM    = 3'd6;
  localparam logic [2:0] MD_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_core.sv
// Radix-2 datapath shared by multiply (shift-add, right shift) and divide (restoring, left shift).
// r_hi/r_lo form the product pair for MUL and the remainder/quotient pair for DIV.
module muldiv_seq_ctrl_core
  import muldiv_seq_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_lo_init,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_add;
  logic [XLEN:0]   w_shl;
  logic [XLEN:0]   w_diff;
  logic            w_ge;

  assign w_sum  = {1'b0, r_hi} + {1'b0, r_opnd};
  assign w_add  = r_lo[0] ? w_sum : {1'b0, r_hi};
  assign w_shl  = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_shl - {1'b0, r_opnd};
  // Partial remainder stays below the divisor, so the top bit of the difference is the borrow.
  assign w_ge   = ~w_diff[XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
    end else if (i_load) begin
      r_hi   <= '0;
      r_lo   <= i_lo_init;
      r_opnd <= i_opnd;
    end else if (i_step) begin
      if (i_is_div) begin
        r_hi <= w_ge ? w_diff[XLEN-1:0] : w_shl[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_ge};
      end else begin
        r_hi <= w_add[XLEN:1];
        r_lo <= {w_add[0], r_lo[XLEN-1:1]};
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// RV64M multiply/divide sequencer: captures operands, iterates the core, fixes signs, and stalls
// the pipeline until the single-cycle res_valid pulse.
module muldiv_seq_ctrl
  import muldiv_seq_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_op_valid,
  input  logic [2:0]      i_op_code,
  input  logic            i_op_word,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_res_valid,
  output logic [XLEN-1:0] o_result,
  output logic [1:0]      o_dbg_state
);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_word;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic             r_special;
  logic [XLEN-1:0]  r_spec_res;
  logic [XLEN-1:0]  r_result;

  // Operand decode, only meaningful while IDLE samples a new op.
  logic            w_s1_signed, w_s2_signed, w_is_div, w_is_rem;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_min_neg;
  logic            w_a_neg, w_b_neg, w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_spec_res, w_lo_init, w_opnd;

  assign w_s1_signed = (i_op_code == MD_OP_MUL) || (i_op_code == MD_OP_MULH) ||
                       (i_op_code == MD_OP_MULHSU) || (i_op_code == MD_OP_DIV) ||
                       (i_op_code == MD_OP_REM);
  assign w_s2_signed = (i_op_code == MD_OP_MUL) || (i_op_code == MD_OP_MULH) ||
                       (i_op_code == MD_OP_DIV) || (i_op_code == MD_OP_REM);
  assign w_is_div    = i_op_code[2];
  assign w_is_rem    = i_op_code[2] & i_op_code[1];

  assign w_a_ext = !i_op_word ? i_src1 :
                   (w_s1_signed ? sext32(i_src1) : {{(XLEN-32){1'b0}}, i_src1[31:0]});
  assign w_b_ext = !i_op_word ? i_src2 :
                   (w_s2_signed ? sext32(i_src2) : {{(XLEN-32){1'b0}}, i_src2[31:0]});
  assign w_a_neg = w_s1_signed & w_a_ext[XLEN-1];
  assign w_b_neg = w_s2_signed & w_b_ext[XLEN-1];
  assign w_a_abs = w_a_neg ? (~w_a_ext + 1'b1) : w_a_ext;
  assign w_b_abs = w_b_neg ? (~w_b_ext + 1'b1) : w_b_ext;

  assign w_min_neg  = i_op_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign w_div_zero = w_is_div & (w_b_ext == '0);
  assign w_ovf      = w_is_div & w_s1_signed & (w_a_ext == w_min_neg) & (w_b_ext == '1);
  assign w_special  = w_div_zero | w_ovf;
  assign w_spec_res = w_div_zero ? (w_is_rem ? w_a_ext : '1)
                                 : (w_is_rem ? '0 : w_a_ext);

  // A 32-bit dividend is left-aligned so 32 steps leave the quotient in the low word.
  assign w_lo_init = !w_is_div ? w_b_abs :
                     (i_op_word ? {w_a_abs[31:0], 32'b0} : w_a_abs);
  assign w_opnd    = w_is_div ? w_b_abs : w_a_abs;

  logic [XLEN-1:0] w_hi, w_lo;

  muldiv_seq_ctrl_core u_core (
    .clk       (clk),
    .rst       (rst),
    .i_load    ((r_state == S_IDLE) && i_op_valid && !i_flush),
    .i_step    ((r_state == S_CALC) && !i_flush),
    .i_is_div  (r_op[2]),
    .i_lo_init (w_lo_init),
    .i_opnd    (w_opnd),
    .o_hi      (w_hi),
    .o_lo      (w_lo)
  );

  // Fix-up: magnitudes were computed unsigned, restore signs, then pick the requested part.
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot_fix, w_rem_fix, w_sel, w_fix_res;

  assign w_prod_fix = r_neg_res ? (~{w_hi, w_lo} + 1'b1) : {w_hi, w_lo};
  assign w_quot_fix = r_neg_res ? (~w_lo + 1'b1) : w_lo;
  assign w_rem_fix  = r_neg_rem ? (~w_hi + 1'b1) : w_hi;

  always_comb begin
    w_sel = '0;
    if (r_special) begin
      w_sel = r_spec_res;
    end else if (!r_op[2]) begin
      if (r_word)
        w_sel = w_prod_fix[XLEN+31:32];
      else if (r_op == MD_OP_MUL)
        w_sel = w_prod_fix[XLEN-1:0];
      else
        w_sel = w_prod_fix[2*XLEN-1:XLEN];
    end else if (r_op[1]) begin
      w_sel = w_rem_fix;
    end else begin
      w_sel = w_quot_fix;
    end
  end

  assign w_fix_res = r_word ? sext32(w_sel) : w_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_word     <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_result   <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_op_valid) begin
            r_op       <= i_op_code;
            r_word     <= i_op_word;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_special  <= w_special;
            r_spec_res <= w_spec_res;
            r_cnt      <= i_op_word ? CNT_W'(32) : CNT_W'(XLEN);
            r_state    <= w_special ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake: the core holds op_valid and operands while stall is high; the op retires in the
  // single cycle where res_valid is high, and stall drops in that same cycle.
  assign o_stall     = i_op_valid && (r_state != S_DONE);
  assign o_res_valid = (r_state == S_DONE) && !i_flush;
  assign o_result    = r_result;
  assign o_dbg_state = r_state;

  a_op_valid_held: assert property (@(posedge clk) disable iff (rst)
    ((r_state == S_CALC) && !i_flush) |-> i_op_valid);

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl: latency, results, special cases, flush and async reset.
module tb_muldiv_seq_ctrl;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic        clk;
  logic        rst;
  logic        i_op_valid;
  logic [2:0]  i_op_code;
  logic        i_op_word;
  logic [63:0] i_src1;
  logic [63:0] i_src2;
  logic        i_flush;
  logic        o_stall;
  logic        o_res_valid;
  logic [63:0] o_result;
  logic [1:0]  o_dbg_state;

  int checks;
  int failures;
  logic [63:0] exp_q[$];

  muldiv_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_op_valid  (i_op_valid),
    .i_op_code   (i_op_code),
    .i_op_word   (i_op_word),
    .i_src1      (i_src1),
    .i_src2      (i_src2),
    .i_flush     (i_flush),
    .o_stall     (o_stall),
    .o_res_valid (o_res_valid),
    .o_result    (o_result),
    .o_dbg_state (o_dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present an op at the next negedge (cycle 0), hold it, and return the cycle index
  // of res_valid, the result, and whether stall was high on every cycle before it and low on it.
  task automatic run_op(input logic [2:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input bit hold, output int lat,
                        output logic [63:0] res, output bit stall_ok);
    @(negedge clk);
    i_op_code  = op;
    i_op_word  = word;
    i_src1     = a;
    i_src2     = b;
    i_op_valid = 1'b1;
    #1;
    stall_ok = (o_stall === 1'b1);
    lat = -1;
    res = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (o_res_valid === 1'b1) begin
        lat = c;
        res = o_result;
        if (o_stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (o_stall !== 1'b1) stall_ok = 1'b0;
    end
    if (!hold) i_op_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
    checks++; if (o_res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", o_res_valid); end
    checks++; if (o_result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", o_result); end
    checks++; if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_dbg_state); end
  endtask

  task automatic test_mul();
    int lat; logic [63:0] res; bit sok;
    run_op(OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, lat, res, sok);
    checks++; if (lat !== 66) begin failures++; $display("FAIL mul_latency got=%0d exp=66", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffffffffffeb", res); end
    checks++; if (sok !== 1'b1) begin failures++; $display("FAIL mul_stall_window got=%b exp=1", sok); end
    run_op(OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, res, sok);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulhu_result got=%h exp=fffffffffffffffe", res); end
    // -1 (signed) x 2 (unsigned) = -2 over 128 bits: high half all ones
    run_op(OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, lat, res, sok);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL mulhsu_result got=%h exp=ffffffffffffffff", res); end
  endtask

  task automatic test_div();
    int lat; logic [63:0] res; bit sok;
    run_op(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, lat, res, sok);
    checks++; if (lat !== 66) begin failures++; $display("FAIL div_latency got=%0d exp=66", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_result got=%h exp=fffffffffffffffd", res); end
    run_op(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, lat, res, sok);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL rem_result got=%h exp=ffffffffffffffff", res); end
    run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 1'b0, lat, res, sok);
    checks++; if (res !== 64'd14) begin failures++; $display("FAIL divu_result got=%h exp=e", res); end
    run_op(OP_REMU, 1'b0, 64'd100, 64'd7, 1'b0, lat, res, sok);
    checks++; if (res !== 64'd2) begin failures++; $display("FAIL remu_result got=%h exp=2", res); end
  endtask

  // Special cases go IDLE -> FIX -> DONE: res_valid in the third cycle, index 2.
  task automatic test_special();
    int lat; logic [63:0] res; bit sok;
    run_op(OP_DIV, 1'b0, 64'd1234, 64'd0, 1'b0, lat, res, sok);
    checks++; if (lat !== 2) begin failures++; $display("FAIL divzero_latency got=%0d exp=2", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divzero_result got=%h exp=ffffffffffffffff", res); end
    checks++; if (sok !== 1'b1) begin failures++; $display("FAIL divzero_stall_window got=%b exp=1", sok); end
    run_op(OP_REM, 1'b0, 64'd5, 64'd0, 1'b0, lat, res, sok);
    checks++; if (res !== 64'd5) begin failures++; $display("FAIL remzero_result got=%h exp=5", res); end
    run_op(OP_DIVU, 1'b0, 64'd5, 64'd0, 1'b0, lat, res, sok);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divuzero_result got=%h exp=ffffffffffffffff", res); end
    run_op(OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, res, sok);
    checks++; if (lat !== 2) begin failures++; $display("FAIL ovf_latency got=%0d exp=2", lat); end
    checks++; if (res !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL ovf_div_result got=%h exp=8000000000000000", res); end
    run_op(OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, res, sok);
    checks++; if (res !== 64'd0) begin failures++; $display("FAIL ovf_rem_result got=%h exp=0", res); end
  endtask

  task automatic test_word();
    int lat; logic [63:0] res; bit sok;
    run_op(OP_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 1'b0, lat, res, sok);
    checks++; if (lat !== 34) begin failures++; $display("FAIL mulw_latency got=%0d exp=34", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulw_result got=%h exp=fffffffffffffffe", res); end
    // Upper words carry junk that a *W op must ignore.
    run_op(OP_DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 1'b0, lat, res, sok);
    checks++; if (lat !== 34) begin failures++; $display("FAIL divw_latency got=%0d exp=34", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL divw_result got=%h exp=fffffffffffffffd", res); end
    run_op(OP_DIV, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, lat, res, sok);
    checks++; if (lat !== 2) begin failures++; $display("FAIL divw_ovf_latency got=%0d exp=2", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL divw_ovf_result got=%h exp=ffffffff80000000", res); end
    run_op(OP_REM, 1'b1, 64'hABCD_0000_0000_0005, 64'hFFFF_FFFF_0000_0000, 1'b0, lat, res, sok);
    checks++; if (res !== 64'd5) begin failures++; $display("FAIL remw_zero_result got=%h exp=5", res); end
  endtask

  // op_valid stays high through DONE; the second op starts only in the following IDLE.
  task automatic test_back_to_back();
    int lat1, lat2; logic [63:0] res1, res2, exp_v; bit sok;
    exp_q.push_back(64'd14);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 1'b1, lat1, res1, sok);
    checks++; if (sok !== 1'b1) begin failures++; $display("FAIL b2b_stall_done got=%b exp=1", sok); end
    run_op(OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, lat2, res2, sok);
    exp_v = exp_q.pop_front();
    checks++; if (res1 !== exp_v) begin failures++; $display("FAIL b2b_first got=%h exp=%h", res1, exp_v); end
    exp_v = exp_q.pop_front();
    checks++; if (res2 !== exp_v) begin failures++; $display("FAIL b2b_second got=%h exp=%h", res2, exp_v); end
    checks++; if (lat2 !== 66) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=66", lat2); end
  endtask

  task automatic test_flush();
    int lat; logic [63:0] res; bit sok; bit seen;
    @(negedge clk);
    i_op_code = OP_MUL; i_op_word = 1'b0; i_src1 = 64'd7; i_src2 = 64'hFFFF_FFFF_FFFF_FFFD;
    i_op_valid = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (o_dbg_state !== 2'd1) begin failures++; $display("FAIL flush_pre_state got=%0d exp=1", o_dbg_state); end
    i_flush = 1'b1;
    i_op_valid = 1'b0;
    @(negedge clk);
    i_flush = 1'b0;
    checks++; if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL flush_state got=%0d exp=0", o_dbg_state); end
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (o_res_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_res_valid got=%b exp=0", seen); end
    run_op(OP_DIVU, 1'b0, 64'd9, 64'd3, 1'b0, lat, res, sok);
    checks++; if (res !== 64'd3) begin failures++; $display("FAIL post_flush_divu got=%h exp=3", res); end
    checks++; if (lat !== 66) begin failures++; $display("FAIL post_flush_latency got=%0d exp=66", lat); end
  endtask

  task automatic test_flush_done();
    @(negedge clk);
    i_op_code = OP_DIVU; i_op_word = 1'b0; i_src1 = 64'd100; i_src2 = 64'd7;
    i_op_valid = 1'b1;
    repeat (66) @(negedge clk);
    checks++; if (o_res_valid !== 1'b1) begin failures++; $display("FAIL flush_done_pre_valid got=%b exp=1", o_res_valid); end
    i_flush = 1'b1;
    #1;
    checks++; if (o_res_valid !== 1'b0) begin failures++; $display("FAIL flush_done_gate got=%b exp=0", o_res_valid); end
    i_op_valid = 1'b0;
    @(negedge clk);
    i_flush = 1'b0;
    checks++; if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL flush_done_state got=%0d exp=0", o_dbg_state); end
  endtask

  task automatic test_async_reset();
    int lat; logic [63:0] res; bit sok;
    checks++; if (o_result !== 64'd14) begin failures++; $display("FAIL pre_reset_result got=%h exp=e", o_result); end
    @(negedge clk);
    i_op_code = OP_MUL; i_op_word = 1'b0; i_src1 = 64'd7; i_src2 = 64'hFFFF_FFFF_FFFF_FFFD;
    i_op_valid = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    i_op_valid = 1'b0;
    #1;
    checks++; if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL arst_state got=%0d exp=0", o_dbg_state); end
    checks++; if (o_result !== 64'd0) begin failures++; $display("FAIL arst_result got=%h exp=0", o_result); end
    checks++; if (o_res_valid !== 1'b0) begin failures++; $display("FAIL arst_res_valid got=%b exp=0", o_res_valid); end
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL arst_stall got=%b exp=0", o_stall); end
    @(negedge clk);
    rst = 1'b0;
    run_op(OP_REMU, 1'b0, 64'd100, 64'd7, 1'b0, lat, res, sok);
    checks++; if (res !== 64'd2) begin failures++; $display("FAIL post_arst_remu got=%h exp=2", res); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    i_op_valid = 1'b0;
    i_op_code = '0;
    i_op_word = 1'b0;
    i_src1 = '0;
    i_src2 = '0;
    i_flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_word();
    test_back_to_back();
    test_flush();
    test_flush_done();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
